// File: rtl/blk_avg_framer_pkg.sv
// -----------------------------------------------------------------------------
// blk_avg_framer_pkg
// Shared definitions for the block-average framer:
//   - wr_state_t : write-side state encoding (S_IDLE, S_ACCEPT, S_DROP)
//   - E_EOB, E_LAST, E_DATA : bit offsets of the fields inside one FIFO entry
//     (entry = {data, last, eob}, eob in bit 0)
// -----------------------------------------------------------------------------
package blk_avg_framer_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,   // next word is word 0 of a block
      S_ACCEPT = 2'd1,   // block admitted, words go to the FIFO
      S_DROP   = 2'd2    // block rejected, words are counted and discarded
   } wr_state_t;

   localparam int unsigned E_EOB  = 0;
   localparam int unsigned E_LAST = 1;
   localparam int unsigned E_DATA = 2;

endpackage

// File: rtl/blk_avg_framer_if.sv
// -----------------------------------------------------------------------------
// blk_avg_framer_if
// AXI-Stream style output bus of the framer, with end-of-block sideband.
//   tdata  : output word (W bits)
//   tvalid : word valid
//   tready : downstream ready
//   tlast  : last word of packet
//   teob   : last word of block (only together with tlast)
// Modports: master (framer side), slave (consumer side).
// -----------------------------------------------------------------------------
interface blk_avg_framer_if #(
   parameter int W = 32
);
   logic [W-1:0] tdata;
   logic         tvalid;
   logic         tready;
   logic         tlast;
   logic         teob;

   modport master (output tdata, output tvalid, output tlast, output teob, input  tready);
   modport slave  (input  tdata, input  tvalid, input  tlast, input  teob, output tready);
endinterface

// File: rtl/blk_avg_framer_sync_fifo_fwft.sv
// -----------------------------------------------------------------------------
// sync_fifo_fwft
// Single-clock first-word-fall-through FIFO, depth 2^AWIDTH.
//   clk, rst  : clock, asynchronous active-low reset (empties the FIFO)
//   wr_en     : write request (accepted when not full, or full with a read)
//   wr_data   : write data
//   rd_en     : read/pop request (ignored when empty)
//   rd_data   : head entry, valid whenever empty == 0
//   fill      : number of stored entries (AWIDTH+1 bits)
//   empty     : no entries stored
//   full      : 2^AWIDTH entries stored
// -----------------------------------------------------------------------------
module sync_fifo_fwft #(
   parameter int WIDTH  = 8,
   parameter int AWIDTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic              rd_en,
   output logic [WIDTH-1:0]  rd_data,
   output logic [AWIDTH:0]   fill,
   output logic              empty,
   output logic              full
);
   localparam int DEPTH = 1 << AWIDTH;

   logic [WIDTH-1:0]  mem [DEPTH];
   logic [AWIDTH-1:0] wr_ptr;
   logic [AWIDTH-1:0] rd_ptr;
   logic              do_wr;
   logic              do_rd;

   assign empty   = (fill == '0);
   // fill never exceeds DEPTH, so its MSB is set only when exactly full.
   assign full    = fill[AWIDTH];
   assign do_rd   = rd_en & ~empty;
   assign do_wr   = wr_en & (~full | do_rd);
   assign rd_data = mem[rd_ptr];

   // NOTE: the storage array has no reset; only pointers and fill carry state
   // that matters, and a reset on the array would turn it into flops.
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fill   <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + AWIDTH'(1);
         if (do_rd) rd_ptr <= rd_ptr + AWIDTH'(1);
         case ({do_wr, do_rd})
            2'b10:   fill <= fill + (AWIDTH+1)'(1);
            2'b01:   fill <= fill - (AWIDTH+1)'(1);
            default: ;
         endcase
      end
   end
endmodule

// File: rtl/blk_avg_framer.sv
// -----------------------------------------------------------------------------
// blk_avg_framer
// Buffers averaged blocks from the block averager and emits them as
// AXI-Stream packets of at most spp words, marking end of block. Only whole
// blocks are admitted: a block whose length does not fit in the free FIFO
// space at its first word is dropped entirely and counted.
//   clk, rst : clock, asynchronous active-low reset
//   din, vin : averaged word and its valid (no backpressure upstream)
//   l        : block length in words (0 disables the framer)
//   spp      : max words per packet (0 = packet ends only at block end)
//   clr      : synchronous clear of ovf and drop_cnt
//   o        : output stream (tdata/tvalid/tready/tlast/teob)
//   ovf      : sticky, at least one block dropped
//   drop_cnt : dropped blocks, saturating
//   blk_cnt  : blocks completely written to the FIFO, wrapping
// -----------------------------------------------------------------------------
module blk_avg_framer
   import blk_avg_framer_pkg::*;
#(
   parameter int DWIDTH  = 32,
   parameter int NIPC    = 1,
   parameter int AWIDTH  = 10,
   parameter int FAWIDTH = 11,
   parameter int PWIDTH  = 10
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [DWIDTH*NIPC-1:0] din,
   input  logic                   vin,
   input  logic [AWIDTH-1:0]      l,
   input  logic [PWIDTH-1:0]      spp,
   input  logic                   clr,
   blk_avg_framer_if.master       o,
   output logic                   ovf,
   output logic [15:0]            drop_cnt,
   output logic [15:0]            blk_cnt
);
   localparam int WW = DWIDTH * NIPC;
   localparam int EW = WW + E_DATA;
   localparam logic [FAWIDTH:0] DEPTH = {1'b1, {FAWIDTH{1'b0}}};

   wr_state_t         state;
   logic [AWIDTH-1:0] l_blk;
   logic [PWIDTH-1:0] spp_blk;
   logic [AWIDTH-1:0] wrd_idx;
   logic [PWIDTH-1:0] pkt_idx;

   logic              wr_en;
   logic              wr_last;
   logic              wr_eob;
   logic [EW-1:0]     wr_data;
   logic [EW-1:0]     rd_data;
   logic [FAWIDTH:0]  fill;
   logic              empty;
   logic              full;
   logic              rd_fire;
   logic [FAWIDTH:0]  free;
   logic              admit;
   logic              blk_end;
   logic              pkt_end;

   // ---------------------------------------------------------------- FIFO
   sync_fifo_fwft #(
      .WIDTH  (EW),
      .AWIDTH (FAWIDTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_data (wr_data),
      .rd_en   (rd_fire),
      .rd_data (rd_data),
      .fill    (fill),
      .empty   (empty),
      .full    (full)
   );

   assign o.tvalid = ~empty;
   assign rd_fire  = o.tvalid & o.tready;
   assign o.tdata  = rd_data[E_DATA +: WW];
   // Flags are masked while empty so the stale head entry never shows up.
   assign o.tlast  = ~empty & rd_data[E_LAST];
   assign o.teob   = ~empty & rd_data[E_EOB];

   // Free space counts a read in the same cycle, so a block can be admitted
   // into a FIFO that is draining at full rate.
   assign free  = DEPTH - fill + {{FAWIDTH{1'b0}}, rd_fire};
   assign admit = (free >= (FAWIDTH+1)'(l));

   assign blk_end = (wrd_idx == l_blk - AWIDTH'(1));
   assign pkt_end = (spp_blk != '0) && (pkt_idx == spp_blk - PWIDTH'(1));

   // ------------------------------------------------------ write decode
   // NOTE: every signal gets a default before the case so no latch is inferred.
   always_comb begin
      wr_en   = 1'b0;
      wr_last = 1'b0;
      wr_eob  = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (vin && (l != '0) && admit) begin
               wr_en   = 1'b1;
               wr_eob  = (l == AWIDTH'(1));
               wr_last = wr_eob | (spp == PWIDTH'(1));
            end
         end
         S_ACCEPT: begin
            if (vin) begin
               wr_en   = 1'b1;
               wr_eob  = blk_end;
               wr_last = blk_end | pkt_end;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      wr_data                = '0;
      wr_data[E_DATA +: WW]  = din;
      wr_data[E_LAST]        = wr_last;
      wr_data[E_EOB]         = wr_eob;
   end

   // ---------------------------------------------------- write-side FSM
   // NOTE: all state here is updated with non-blocking assignments, so every
   // branch sees the pre-edge values of the counters and the later clr
   // override cleanly replaces any drop update from the same cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_IDLE;
         l_blk    <= '0;
         spp_blk  <= '0;
         wrd_idx  <= '0;
         pkt_idx  <= '0;
         ovf      <= 1'b0;
         drop_cnt <= '0;
         blk_cnt  <= '0;
      end else begin
         if (vin) begin
            unique case (state)
               S_IDLE: begin
                  if (l != '0) begin
                     l_blk   <= l;
                     spp_blk <= spp;
                     if (admit) begin
                        if (l == AWIDTH'(1)) begin
                           blk_cnt <= blk_cnt + 16'd1;
                        end else begin
                           state   <= S_ACCEPT;
                           wrd_idx <= AWIDTH'(1);
                           pkt_idx <= (spp == PWIDTH'(1)) ? '0 : PWIDTH'(1);
                        end
                     end else begin
                        ovf <= 1'b1;
                        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
                        if (l != AWIDTH'(1)) begin
                           state   <= S_DROP;
                           wrd_idx <= AWIDTH'(1);
                        end
                     end
                  end
               end
               S_ACCEPT: begin
                  pkt_idx <= wr_last ? '0 : pkt_idx + PWIDTH'(1);
                  if (blk_end) begin
                     state   <= S_IDLE;
                     wrd_idx <= '0;
                     blk_cnt <= blk_cnt + 16'd1;
                  end else begin
                     wrd_idx <= wrd_idx + AWIDTH'(1);
                  end
               end
               S_DROP: begin
                  if (blk_end) begin
                     state   <= S_IDLE;
                     wrd_idx <= '0;
                  end else begin
                     wrd_idx <= wrd_idx + AWIDTH'(1);
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
         // clr has priority over a drop in the same cycle.
         if (clr) begin
            ovf      <= 1'b0;
            drop_cnt <= '0;
         end
      end
   end

   // Admission reserves l_blk entries, so a write into a full FIFO without a
   // simultaneous read would mean the reservation logic is broken.
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
                                   !(wr_en && full && !rd_fire));
endmodule

// File: tb/tb_blk_avg_framer.sv
// -----------------------------------------------------------------------------
// tb_blk_avg_framer
// Directed test of blk_avg_framer with a 16-entry FIFO. Expected packets and
// counter values are written out by hand for each scenario.
// -----------------------------------------------------------------------------
module tb_blk_avg_framer;
   localparam int DW  = 32;
   localparam int AW  = 4;
   localparam int FAW = 4;
   localparam int PW  = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] din;
   logic          vin;
   logic [AW-1:0] l;
   logic [PW-1:0] spp;
   logic          clr;
   logic          ovf;
   logic [15:0]   drop_cnt;
   logic [15:0]   blk_cnt;

   blk_avg_framer_if #(.W(DW)) o_if ();

   blk_avg_framer #(
      .DWIDTH  (DW),
      .NIPC    (1),
      .AWIDTH  (AW),
      .FAWIDTH (FAW),
      .PWIDTH  (PW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .din      (din),
      .vin      (vin),
      .l        (l),
      .spp      (spp),
      .clr      (clr),
      .o        (o_if.master),
      .ovf      (ovf),
      .drop_cnt (drop_cnt),
      .blk_cnt  (blk_cnt)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Received words as {data, last, eob}, captured at the falling edge
   // ahead of the rising edge that completes the transfer.
   logic [DW+1:0] rx_q [$];
   logic [DW+2:0] held;
   logic          stalled = 1'b0;

   always @(negedge clk) begin
      if (!rst) begin
         stalled = 1'b0;
      end else begin
         if (stalled)
            check("hold", {o_if.tvalid, o_if.tdata, o_if.tlast, o_if.teob}, held);
         if (o_if.tvalid && o_if.tready)
            rx_q.push_back({o_if.tdata, o_if.tlast, o_if.teob});
         stalled = o_if.tvalid && !o_if.tready;
         held    = {o_if.tvalid, o_if.tdata, o_if.tlast, o_if.teob};
      end
   end

   task automatic send(input logic [DW-1:0] d);
      din = d;
      vin = 1'b1;
      @(posedge clk); #1;
      vin = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Pops n words and compares each against base+i with the given flag masks.
   task automatic check_block(input string tag, input int n, input logic [DW-1:0] base,
                              input logic [15:0] last_mask, input logic [15:0] eob_mask);
      check({tag, "_cnt"}, 64'(rx_q.size() >= n), 64'd1);
      for (int i = 0; i < n; i++) begin
         logic [DW+1:0] e;
         logic [DW+1:0] g;
         e = {base + DW'(i), last_mask[i], eob_mask[i]};
         g = (rx_q.size() != 0) ? rx_q.pop_front() : '0;
         check($sformatf("%s_w%0d", tag, i), g, e);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b0; din = '0; vin = 1'b0; l = '0; spp = '0; clr = 1'b0;
      o_if.tready = 1'b1;
      idle(3);
      check("rst_tvalid", o_if.tvalid, 0);
      check("rst_tlast",  o_if.tlast,  0);
      check("rst_teob",   o_if.teob,   0);
      check("rst_ovf",    ovf,         0);
      check("rst_drop",   drop_cnt,    0);
      check("rst_blk",    blk_cnt,     0);
      @(negedge clk); rst = 1'b1;
      idle(2);

      // Framing: 8 words in packets of 3,3,2.
      l = 4'd8; spp = 4'd3;
      check("lat_before", o_if.tvalid, 0);
      send(32'h100);
      check("lat_after", o_if.tvalid, 1);
      for (int i = 1; i < 8; i++) send(32'h100 + 32'(i));
      idle(10);
      check_block("frame", 8, 32'h100, 16'b1010_0100, 16'b1000_0000);
      check("frame_blk", blk_cnt, 1);
      check("frame_empty", 64'(rx_q.size()), 0);

      // Packet limit disabled.
      l = 4'd5; spp = 4'd0;
      for (int i = 0; i < 5; i++) send(32'h200 + 32'(i));
      idle(10);
      check_block("nospp", 5, 32'h200, 16'b1_0000, 16'b1_0000);
      check("nospp_blk", blk_cnt, 2);

      // Backpressure with tready toggling every cycle.
      l = 4'd4; spp = 4'd4;
      fork
         for (int i = 0; i < 4; i++) send(32'h300 + 32'(i));
         for (int k = 0; k < 16; k++) begin
            o_if.tready = (k % 2 == 0);
            @(posedge clk); #1;
         end
      join
      o_if.tready = 1'b1;
      idle(6);
      check_block("bp", 4, 32'h300, 16'b1000, 16'b1000);
      check("bp_blk", blk_cnt, 3);

      // l changes mid-block: current block keeps 6, next block uses 3.
      l = 4'd6; spp = 4'd0;
      for (int i = 0; i < 6; i++) begin
         if (i == 2) l = 4'd3;
         send(32'h400 + 32'(i));
      end
      for (int i = 0; i < 3; i++) send(32'h500 + 32'(i));
      idle(10);
      check_block("cfg6", 6, 32'h400, 16'b10_0000, 16'b10_0000);
      check_block("cfg3", 3, 32'h500, 16'b100, 16'b100);
      check("cfg_blk", blk_cnt, 5);

      // Drop on full: 16-deep FIFO, two blocks of 10 with tready low.
      l = 4'd10; spp = 4'd0; o_if.tready = 1'b0;
      for (int i = 0; i < 10; i++) send(32'h600 + 32'(i));
      check("full1_blk", blk_cnt, 6);
      check("full1_ovf", ovf, 0);
      for (int i = 0; i < 10; i++) send(32'h700 + 32'(i));
      idle(2);
      check("drop_ovf",  ovf,      1);
      check("drop_cnt",  drop_cnt, 1);
      check("drop_blk",  blk_cnt,  6);
      check("drop_none", 64'(rx_q.size()), 0);
      o_if.tready = 1'b1;
      idle(20);
      check("drain_n", 64'(rx_q.size()), 10);
      check_block("drain", 10, 32'h600, 16'b10_0000_0000, 16'b10_0000_0000);
      for (int i = 0; i < 10; i++) send(32'h800 + 32'(i));
      idle(15);
      check_block("after", 10, 32'h800, 16'b10_0000_0000, 16'b10_0000_0000);
      check("after_blk",  blk_cnt,  7);
      check("after_drop", drop_cnt, 1);

      // clr pulse.
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      check("clr_ovf",  ovf,      0);
      check("clr_drop", drop_cnt, 0);

      // Reset in the middle of a packet.
      l = 4'd8; spp = 4'd3;
      send(32'h900);
      send(32'h901);
      din = 32'h902; vin = 1'b1; rst = 1'b0;
      #1;
      check("mrst_tvalid", o_if.tvalid, 0);
      check("mrst_blk",    blk_cnt,     0);
      check("mrst_drop",   drop_cnt,    0);
      vin = 1'b0;
      idle(2);
      @(negedge clk); rst = 1'b1;
      idle(2);
      rx_q.delete();
      for (int i = 0; i < 8; i++) send(32'hA00 + 32'(i));
      idle(10);
      check_block("post", 8, 32'hA00, 16'b1010_0100, 16'b1000_0000);
      check("post_blk",   blk_cnt, 1);
      check("post_empty", 64'(rx_q.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
